mch_enc_dat: RTL

Manchester encoder datapath. Sits directly downstream of the Manchester encoder controller and consumes its frame state (stm), half-bit phase pulses (pls1m, pls2m) and bit index (q80). It latches a 56-bit payload and serialises an 80-bit frame onto a Manchester line:
- 12 preamble bits
- 56 data bits, MSB first
- 12 trailer bits

---
 rtl/mch_pkg.sv | 30 +++
 rtl/mch_crc8.sv | 29 ++
 rtl/mch_enc_dat.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mch_pkg.sv
// Shared definitions for the Manchester encoder datapath: controller state
// encodings, frame index bounds, widths and the serial CRC-8 step function.
package mch_pkg;

    localparam int DAT_W = 56;
    localparam int IDX_W = 7;

    typedef enum logic [1:0] {
        ST_PRE  = 2'd0,
        ST_DAT  = 2'd1,
        ST_TRL  = 2'd2,
        ST_IDLE = 2'd3
    } stm_t;

    localparam logic [IDX_W-1:0] PRE_END  = 7'd11;
    localparam logic [IDX_W-1:0] DAT_END  = 7'd67;
    localparam logic [IDX_W-1:0] CRC_END  = 7'd75;
    localparam logic [IDX_W-1:0] TRL_END  = 7'd79;
    localparam logic [IDX_W-1:0] IDX_IDLE = 7'd127;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One MSB-first shift of a non-reflected CRC-8 with the data bit folded in.
    function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mch_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR).
// Clear has priority over enable.
module mch_crc8
    import mch_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    // Accumulate one data bit per enabled cycle; clear restarts the checksum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= 8'h00;
        end else if (i_clr) begin
            r_crc <= 8'h00;
        end else if (i_en) begin
            r_crc <= crc8Step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mch_enc_dat.sv
// Manchester encoder datapath. Follows the controller's state, bit index and
// half-bit phase, and drives an 80-bit frame (12 preamble, 56 data MSB first,
// 12 trailer) onto a registered Manchester line.
// Optional feature macro: CRC8_EN -- puts a CRC-8 of the data bits in the
// first 8 trailer bits and adds the o_phase_err output.
module mch_enc_dat
    import mch_pkg::*;
#(
    parameter logic [11:0] PRE_PAT  = 12'hAAB,
    parameter logic [11:0] TRL_PAT  = 12'h0F0,
    parameter logic        IDLE_LVL = 1'b0
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DAT_W-1:0] i_din,
    input  logic [1:0]       i_stm,
    input  logic             i_pls1m,
    input  logic             i_pls2m,
    input  logic [IDX_W-1:0] i_q80,
    output logic             o_txd,
    output logic             o_txen,
    output logic             o_busy,
    output logic             o_done
`ifdef CRC8_EN
    ,
    output logic             o_phase_err
`endif
);

    logic [DAT_W-1:0] r_payload;
    logic             r_txd;
    logic             r_txen;
    logic             r_done;
    stm_t             r_stm_d;
    logic [IDX_W-1:0] r_q80_d;

    logic             w_busy;
    logic             w_load_ok;
    logic             w_boundary;
    logic             w_bit;

    assign w_busy     = (i_stm != ST_IDLE);
    assign w_load_ok  = i_load & ~w_busy;
    assign w_boundary = (i_q80 != r_q80_d);

`ifdef CRC8_EN
    logic [7:0] w_crc;
    logic       w_crc_clr;
    logic       w_crc_en;
    logic [1:0] w_phase;
    logic [1:0] r_phase_d;
    logic       r_phase_err;

    assign w_crc_clr = w_load_ok |
                       ((i_stm == ST_PRE) && (i_q80 == 7'd0) && w_boundary);
    assign w_crc_en  = w_boundary && (i_stm == ST_DAT);
    assign w_phase   = {i_pls1m, i_pls2m};

    mch_crc8 u_crc (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_crc_clr),
        .i_en  (w_crc_en),
        .i_bit (w_bit),
        .o_crc (w_crc)
    );

    // Phase must stay or step by one (mod 4) between consecutive in-frame cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase_d   <= 2'b00;
            r_phase_err <= 1'b0;
        end else begin
            r_phase_d <= w_phase;
            if (w_load_ok) begin
                r_phase_err <= 1'b0;
            end else if (w_busy && (r_stm_d != ST_IDLE) &&
                         (w_phase != r_phase_d) &&
                         (w_phase != (r_phase_d + 2'd1))) begin
                r_phase_err <= 1'b1;
            end
        end
    end

    assign o_phase_err = r_phase_err;
`else
    // Phase input and bit boundary only matter to the checksum/phase logic.
    logic w_unused;
    assign w_unused = ^{i_pls2m, w_boundary};
`endif

    // Pick the frame bit addressed by the controller's bit index.
    always_comb begin
        w_bit = 1'b0;
        if (i_q80 <= PRE_END) begin
            w_bit = PRE_PAT[4'(PRE_END - i_q80)];
        end else if (i_q80 <= DAT_END) begin
            w_bit = r_payload[6'(DAT_END - i_q80)];
        end else if (i_q80 <= TRL_END) begin
`ifdef CRC8_EN
            if (i_q80 <= CRC_END) begin
                w_bit = w_crc[3'(CRC_END - i_q80)];
            end else begin
                w_bit = TRL_PAT[4'(TRL_END - i_q80)];
            end
`else
            w_bit = TRL_PAT[4'(TRL_END - i_q80)];
`endif
        end
    end

    // Payload is only replaced between frames so an in-flight frame stays intact.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_payload <= '0;
        end else if (w_load_ok) begin
            r_payload <= i_din;
        end
    end

    // Line encode: a 1 is low-then-high, a 0 is high-then-low, one clock behind the controller.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_txd  <= IDLE_LVL;
            r_txen <= 1'b0;
        end else begin
            r_txd  <= w_busy ? ~(w_bit ^ i_pls1m) : IDLE_LVL;
            r_txen <= w_busy;
        end
    end

    // Delayed controller state/index for edge detection of frame end and bit boundaries.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stm_d <= ST_IDLE;
            r_q80_d <= IDX_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_stm_d <= stm_t'(i_stm);
            r_q80_d <= i_q80;
            r_done  <= (r_stm_d == ST_TRL) && (i_stm == ST_IDLE);
        end
    end

    assign o_txd  = r_txd;
    assign o_txen = r_txen;
    assign o_busy = w_busy;
    assign o_done = r_done;

endmodule
